// File: rtl/rbshift_arb.sv
// Round-robin arbiter sharing one rotate-right barrel shifter among NREQ requesters.
// Optional build macro RBSHIFT_ARB_DIR_EN adds a per-requester req_dir port (1 = rotate left).

module rbshift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] amt,
    output logic [WIDTH-1:0]         result_c
);
    localparam int unsigned AW = $clog2(WIDTH);

    // Bit i of the result comes from bit (i + amt) mod WIDTH; WIDTH is a power of two so AW bits wrap.
    always_comb begin
        result_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            result_c[i] = data[AW'(i) + amt];
        end
    end
endmodule

module rbshift_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*WIDTH-1:0]           req_data,
    input  logic [NREQ*$clog2(WIDTH)-1:0]   req_amt,
`ifdef RBSHIFT_ARB_DIR_EN
    input  logic [NREQ-1:0]                 req_dir,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [$clog2(NREQ)-1:0]         out_id
);
    localparam int unsigned AW  = $clog2(WIDTH);
    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win;
    logic             found;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] win_data;
    logic [AW-1:0]    win_amt;
    logic [AW-1:0]    amt_eff;
    logic [WIDTH-1:0] rot_c;

    // Round-robin search starting at rr_ptr, wrapping at NREQ-1.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = rr_ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign can_load = (state_q == EMPTY) | out_ready;
    assign accept   = rst_n & found & can_load;
    assign win_data = req_data[32'(win)*WIDTH +: WIDTH];
    assign win_amt  = req_amt[32'(win)*AW +: AW];

`ifdef RBSHIFT_ARB_DIR_EN
    // Left rotate by a equals right rotate by (WIDTH - a) mod WIDTH; AW-bit wrap does the mod.
    assign amt_eff = req_dir[win] ? (AW'(0) - win_amt) : win_amt;
`else
    assign amt_eff = win_amt;
`endif

    rbshift #(.WIDTH(WIDTH)) u_rbshift (
        .data     (win_data),
        .amt      (amt_eff),
        .result_c (rot_c)
    );

    // Only the winner sees ready, and only when the output register can take a result.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (accept) state_d = FULL;
                     else if (out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign out_valid = (state_q == FULL);

    // Result payload and priority pointer move only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            out_data <= rot_c;
            out_id   <= win;
            rr_ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end
endmodule

// File: tb/tb_rbshift_arb.sv
// Self-checking bench for rbshift_arb (WIDTH=8, NREQ=4): reference model plus result scoreboard.
// Build with RBSHIFT_ARB_DIR_EN defined to also exercise left rotation.

module tb_rbshift_arb;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_amt;
    logic [3:0]  req_dir;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    int total = 0;
    int bad   = 0;

    bit         m_valid;
    logic [1:0] m_rr;
    logic [3:0] m_acc;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    rbshift_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
`ifdef RBSHIFT_ARB_DIR_EN
        .req_dir   (req_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] rot_model(input logic [7:0] d, input logic [2:0] a, input logic dir);
        logic [15:0] t;
        if (dir) begin
            t = {d, d} << a;
            return t[15:8];
        end
        t = {d, d} >> a;
        return t[7:0];
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [2:0] a,
                           input logic dr);
        req_valid[i]       = v;
        req_data[i*8 +: 8] = d;
        req_amt[i*3 +: 3]  = a;
        req_dir[i]         = dr;
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_rr    = 2'd0;
        m_acc   = 4'd0;
    endtask

    // Called just after a negedge with inputs driven; checks, updates model, advances one cycle.
    task automatic step();
        logic [3:0] exp_rdy;
        logic [9:0] e;
        logic [7:0] d;
        logic [2:0] a;
        logic       dr;
        int         win;
        bit         found;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid && q.size() > 0) begin
            e = q[0];
            check("out_data", 32'(out_data), 32'(e[7:0]));
            check("out_id", 32'(out_id), 32'(e[9:8]));
        end
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(m_rr) + k) % 4;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        exp_rdy = 4'd0;
        if (found && (!m_valid || out_ready)) exp_rdy[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_valid && out_ready) void'(q.pop_front());
        m_acc = exp_rdy;
        if (exp_rdy != 4'd0) begin
            d  = req_data[win*8 +: 8];
            a  = req_amt[win*3 +: 3];
            dr = 1'b0;
`ifdef RBSHIFT_ARB_DIR_EN
            dr = req_dir[win];
`endif
            q.push_back({2'(win), rot_model(d, a, dr)});
            m_rr    = (win == 3) ? 2'd0 : 2'(win + 1);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_dir   = 4'd0;
        req_valid = 4'd0;
        req_data  = 32'd0;
        req_amt   = 12'd0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h11 * (i + 1)), 3'(i + 1), 1'b0);

        // Reset with every requester asking
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All four valid: grants 0,1,2,3,0,...
        for (int c = 0; c < 8; c++) step();

        // Single requester 2: 81 rotr 1 = C0
        for (int i = 0; i < 4; i++) req_valid[i] = 1'b0;
        set_req(2, 1'b1, 8'h81, 3'd1, 1'b0);
        step();
        req_valid[2] = 1'b0;
        #1;
        check("t2_data", 32'(out_data), 32'hC0);
        check("t2_id", 32'(out_id), 32'd2);
        step();

        // Back-pressure with 0F pending, then drain+load in the same edge
        set_req(3, 1'b1, 8'h0F, 3'd0, 1'b0);
        step();
        req_valid[3] = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 8'(8'h30 + i), 3'(i + 2), 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_data", 32'(out_data), 32'h0F);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // A5 with amounts 0,4,7 -> A5, 5A, 4B
        for (int i = 0; i < 4; i++) req_valid[i] = 1'b0;
        set_req(1, 1'b1, 8'hA5, 3'd0, 1'b0);
        step();
        #1 check("a5_amt0", 32'(out_data), 32'hA5);
        set_req(1, 1'b1, 8'hA5, 3'd4, 1'b0);
        step();
        #1 check("a5_amt4", 32'(out_data), 32'h5A);
        set_req(1, 1'b1, 8'hA5, 3'd7, 1'b0);
        step();
        #1 check("a5_amt7", 32'(out_data), 32'h4B);
        req_valid[1] = 1'b0;
        step();

`ifdef RBSHIFT_ARB_DIR_EN
        // Direction: 81 rotl 1 = 03, rotr 1 = C0
        set_req(0, 1'b1, 8'h81, 3'd1, 1'b1);
        step();
        #1 check("dir_left", 32'(out_data), 32'h03);
        set_req(0, 1'b1, 8'h81, 3'd1, 1'b0);
        step();
        #1 check("dir_right", 32'(out_data), 32'hC0);
        req_valid[0] = 1'b0;
        step();
`endif

        // Random traffic; unaccepted requests keep their payload
        m_acc = 4'd0;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    set_req(i, 1'($urandom_range(0, 2) != 0), 8'($urandom), 3'($urandom),
                            1'($urandom));
                end
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // Reset while a result is pending
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h5C + i), 3'(i), 1'b0);
        out_ready = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // Drain
        req_valid = 4'd0;
        for (int c = 0; c < 3; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
